// File: rtl/gate_pkg.sv
// Shared types and defaults for the car-park gate sensor decoder.
// The optional input debounce is enabled by defining GATE_DEBOUNCE_EN.
`timescale 1ns/1ps
package gate_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ENT_A,
      ST_ENT_AB,
      ST_ENT_B,
      ST_EXT_B,
      ST_EXT_BA,
      ST_EXT_A,
      ST_CLEAR,
      ST_FAULT
   } gate_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

   // Width needed for a dwell counter that must be able to hold the timeout value itself.
   function automatic int dwellWidth(input int timeoutCycles);
      return $clog2(timeoutCycles + 1);
   endfunction

endpackage

// File: rtl/sensor_filter.sv
// One beam input: 2-flop synchronizer followed, when GATE_DEBOUNCE_EN is defined,
// by a consecutive-cycle debounce filter.
`timescale 1ns/1ps
module sensor_filter #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level
);

   logic [1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
      end
   end

`ifdef GATE_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] r_count;
   logic             r_level;
   logic             w_differs;

   assign w_differs = r_sync[1] ^ r_level;

   // Any cycle where the raw level agrees with the accepted one restarts the run.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_level <= 1'b0;
      end else if (!w_differs) begin
         r_count <= '0;
      end else if (r_count == CNT_LAST) begin
         r_level <= r_sync[1];
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_level = r_level;
`else
   // Unfiltered build: the debounce depth has no effect on the passthrough.
   if (DEBOUNCE_CYCLES >= 0) begin : g_raw
      assign o_level = r_sync[1];
   end else begin : g_rawAlt
      assign o_level = r_sync[1];
   end
`endif

endmodule

// File: rtl/gate_sensor_decoder.sv
// Gate beam-order FSM: turns filtered outer (A) / inner (B) beam levels into single-cycle
// entry/exit pulses and flags stuck sensors. Debounce enabled by defining GATE_DEBOUNCE_EN.
`timescale 1ns/1ps
module gate_sensor_decoder
   import gate_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sens_a,
   input  logic i_sens_b,
   output logic o_entry,
   output logic o_exit,
   output logic o_busy,
   output logic o_fault
);

   localparam int DWELL_W = dwellWidth(TIMEOUT_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(TIMEOUT_CYCLES);

   logic               w_a;
   logic               w_b;
   gate_state_t        r_state;
   gate_state_t        w_nextState;
   logic [DWELL_W-1:0] r_dwell;
   logic               w_timeout;
   logic               w_entryNext;
   logic               w_exitNext;
   logic               w_busyNext;
   logic               w_faultNext;

   sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filterA (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (i_sens_a),
      .o_level (w_a)
   );

   sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filterB (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (i_sens_b),
      .o_level (w_b)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Dwell restarts on every state change and saturates so a long idle never wraps.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_dwell <= '0;
      end else if (w_nextState != r_state) begin
         r_dwell <= '0;
      end else if (r_dwell != DWELL_LIMIT) begin
         r_dwell <= r_dwell + 1'b1;
      end
   end

   assign w_timeout = (r_dwell == DWELL_LIMIT) && (r_state != ST_IDLE) && (r_state != ST_FAULT);

   // A stalled crossing goes to FAULT even if the beams happen to move on that same cycle.
   always_comb begin
      w_nextState = r_state;
      if (w_timeout) begin
         w_nextState = ST_FAULT;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               case ({w_a, w_b})
                  2'b10:   w_nextState = ST_ENT_A;
                  2'b01:   w_nextState = ST_EXT_B;
                  2'b11:   w_nextState = ST_CLEAR;
                  default: w_nextState = ST_IDLE;
               endcase
            end
            ST_ENT_A: begin
               case ({w_a, w_b})
                  2'b11:   w_nextState = ST_ENT_AB;
                  2'b00:   w_nextState = ST_IDLE;
                  2'b01:   w_nextState = ST_CLEAR;
                  default: w_nextState = ST_ENT_A;
               endcase
            end
            ST_ENT_AB: begin
               case ({w_a, w_b})
                  2'b01:   w_nextState = ST_ENT_B;
                  2'b10:   w_nextState = ST_ENT_A;
                  2'b00:   w_nextState = ST_CLEAR;
                  default: w_nextState = ST_ENT_AB;
               endcase
            end
            ST_ENT_B: begin
               case ({w_a, w_b})
                  2'b00:   w_nextState = ST_IDLE;
                  2'b11:   w_nextState = ST_ENT_AB;
                  2'b10:   w_nextState = ST_CLEAR;
                  default: w_nextState = ST_ENT_B;
               endcase
            end
            ST_EXT_B: begin
               case ({w_a, w_b})
                  2'b11:   w_nextState = ST_EXT_BA;
                  2'b00:   w_nextState = ST_IDLE;
                  2'b10:   w_nextState = ST_CLEAR;
                  default: w_nextState = ST_EXT_B;
               endcase
            end
            ST_EXT_BA: begin
               case ({w_a, w_b})
                  2'b10:   w_nextState = ST_EXT_A;
                  2'b01:   w_nextState = ST_EXT_B;
                  2'b00:   w_nextState = ST_CLEAR;
                  default: w_nextState = ST_EXT_BA;
               endcase
            end
            ST_EXT_A: begin
               case ({w_a, w_b})
                  2'b00:   w_nextState = ST_IDLE;
                  2'b11:   w_nextState = ST_EXT_BA;
                  2'b01:   w_nextState = ST_CLEAR;
                  default: w_nextState = ST_EXT_A;
               endcase
            end
            ST_CLEAR, ST_FAULT: begin
               if (!w_a && !w_b) begin
                  w_nextState = ST_IDLE;
               end
            end
            default: w_nextState = ST_IDLE;
         endcase
      end
   end

   // Only the final step of an ordered crossing back to IDLE produces an event.
   always_comb begin
      w_entryNext = (r_state == ST_ENT_B) && (w_nextState == ST_IDLE);
      w_exitNext  = (r_state == ST_EXT_A) && (w_nextState == ST_IDLE);
      w_busyNext  = (w_nextState != ST_IDLE);
      w_faultNext = (w_nextState == ST_FAULT);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_entry <= 1'b0;
         o_exit  <= 1'b0;
         o_busy  <= 1'b0;
         o_fault <= 1'b0;
      end else begin
         o_entry <= w_entryNext;
         o_exit  <= w_exitNext;
         o_busy  <= w_busyNext;
         o_fault <= w_faultNext;
      end
   end

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Self-checking bench for gate_sensor_decoder: directed crossings plus random beam
// activity against a crossing-progress reference model.
`timescale 1ns/1ps
module tb_gate_sensor_decoder;

   localparam int TB_DEBOUNCE = 4;
   localparam int TB_TIMEOUT  = 40;

   localparam int PH_IDLE  = 0;
   localparam int PH_CROSS = 1;
   localparam int PH_CLEAR = 2;
   localparam int PH_FAULT = 3;

   logic clk   = 1'b0;
   logic rstN  = 1'b0;
   logic sensA = 1'b0;
   logic sensB = 1'b0;
   logic entry;
   logic exitEv;
   logic busy;
   logic fault;

   int total = 0;
   int bad   = 0;

   // Reference model: a crossing is a direction plus a step 1..3 along lead/trail beams
   int mPhase;
   bit mInbound;
   int mStep;
   int mDwell;
   bit mS1A, mS2A, mS1B, mS2B;
   bit mLvlA, mLvlB;
   int mRunA, mRunB;
   bit expEntry, expExit, expBusy, expFault;

   int seenEntry, seenExit, seenBusy;

   always #5 clk = ~clk;

   gate_sensor_decoder #(
      .DEBOUNCE_CYCLES (TB_DEBOUNCE),
      .TIMEOUT_CYCLES  (TB_TIMEOUT)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rstN),
      .i_sens_a (sensA),
      .i_sens_b (sensB),
      .o_entry  (entry),
      .o_exit   (exitEv),
      .o_busy   (busy),
      .o_fault  (fault)
   );

   // Expected {lead, trail} beam pattern while at a given crossing step.
   function automatic bit [1:0] stepPattern(input int step);
      case (step)
         1:       return 2'b10;
         2:       return 2'b11;
         3:       return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   task automatic modelReset();
      mPhase = PH_IDLE; mInbound = 1'b0; mStep = 0; mDwell = 0;
      mS1A = 0; mS2A = 0; mS1B = 0; mS2B = 0;
      mLvlA = 0; mLvlB = 0; mRunA = 0; mRunB = 0;
      expEntry = 0; expExit = 0; expBusy = 0; expFault = 0;
   endtask

   task automatic modelEdge(input bit rawA, input bit rawB, input bit rstActive);
      int nPhase;
      int nStep;
      bit nIn;
      bit evIn;
      bit evOut;
      bit changed;
      bit [1:0] lt;
      if (rstActive) begin
         modelReset();
         return;
      end
`ifndef GATE_DEBOUNCE_EN
      mLvlA = mS2A;
      mLvlB = mS2B;
`endif
      nPhase = mPhase; nStep = mStep; nIn = mInbound; evIn = 0; evOut = 0;
      if ((mPhase == PH_CROSS || mPhase == PH_CLEAR) && mDwell >= TB_TIMEOUT) begin
         nPhase = PH_FAULT;
      end else begin
         case (mPhase)
            PH_IDLE: begin
               if (mLvlA && mLvlB) nPhase = PH_CLEAR;
               else if (mLvlA || mLvlB) begin
                  nPhase = PH_CROSS; nIn = mLvlA; nStep = 1;
               end
            end
            PH_CLEAR, PH_FAULT: begin
               if (!mLvlA && !mLvlB) nPhase = PH_IDLE;
            end
            default: begin
               lt = mInbound ? {mLvlA, mLvlB} : {mLvlB, mLvlA};
               if (lt == 2'b00) begin
                  if (mStep == 2) nPhase = PH_CLEAR;
                  else begin
                     nPhase = PH_IDLE;
                     if (mStep == 3) begin
                        evIn = mInbound; evOut = !mInbound;
                     end
                  end
               end else if (mStep < 3 && lt == stepPattern(mStep + 1)) nStep = mStep + 1;
               else if (mStep > 1 && lt == stepPattern(mStep - 1)) nStep = mStep - 1;
               else if (lt != stepPattern(mStep)) nPhase = PH_CLEAR;
            end
         endcase
      end
      changed = (nPhase != mPhase) || (nPhase == PH_CROSS && (nStep != mStep || nIn != mInbound));
      mDwell = changed ? 0 : mDwell + 1;
      mPhase = nPhase; mStep = nStep; mInbound = nIn;
`ifdef GATE_DEBOUNCE_EN
      if (mS2A != mLvlA) begin
         mRunA++;
         if (mRunA == TB_DEBOUNCE) begin mLvlA = mS2A; mRunA = 0; end
      end else mRunA = 0;
      if (mS2B != mLvlB) begin
         mRunB++;
         if (mRunB == TB_DEBOUNCE) begin mLvlB = mS2B; mRunB = 0; end
      end else mRunB = 0;
`endif
      mS2A = mS1A; mS1A = rawA;
      mS2B = mS1B; mS1B = rawB;
      expEntry = evIn;
      expExit  = evOut;
      expBusy  = (mPhase != PH_IDLE);
      expFault = (mPhase == PH_FAULT);
   endtask

   task automatic checkOutput(input string tag);
      total++;
      assert (entry === expEntry) else begin
         bad++; $error("[TB] FAIL %s.entry observed=%0b expected=%0b", tag, entry, expEntry);
      end
      total++;
      assert (exitEv === expExit) else begin
         bad++; $error("[TB] FAIL %s.exit observed=%0b expected=%0b", tag, exitEv, expExit);
      end
      total++;
      assert (busy === expBusy) else begin
         bad++; $error("[TB] FAIL %s.busy observed=%0b expected=%0b", tag, busy, expBusy);
      end
      total++;
      assert (fault === expFault) else begin
         bad++; $error("[TB] FAIL %s.fault observed=%0b expected=%0b", tag, fault, expFault);
      end
      total++;
      assert (!(entry === 1'b1 && exitEv === 1'b1)) else begin
         bad++; $error("[TB] FAIL %s.exclusive observed=both expected=not both", tag);
      end
      if (entry === 1'b1) seenEntry++;
      if (exitEv === 1'b1) seenExit++;
      if (busy === 1'b1) seenBusy++;
   endtask

   task automatic checkCount(input string tag, input int observed, input int expected);
      total++;
      assert (observed == expected) else begin
         bad++; $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic stepCycle(input string tag);
      @(posedge clk);
      modelEdge(sensA, sensB, !rstN);
      #1;
      checkOutput(tag);
   endtask

   task automatic applyStimulus(input bit a, input bit b, input int cycles, input string tag);
      sensA = a;
      sensB = b;
      repeat (cycles) stepCycle(tag);
   endtask

   task automatic clearSeen();
      seenEntry = 0; seenExit = 0; seenBusy = 0;
   endtask

   initial begin
      modelReset();
      clearSeen();
      #2;
      rstN = 1'b0;
      applyStimulus(0, 0, 3, "reset");
      rstN = 1'b1;

      clearSeen();
      applyStimulus(1, 0, 20, "in.a");
      applyStimulus(1, 1, 20, "in.ab");
      applyStimulus(0, 1, 20, "in.b");
      applyStimulus(0, 0, 20, "in.clr");
      checkCount("in.entryCount", seenEntry, 1);
      checkCount("in.exitCount", seenExit, 0);
      checkCount("in.busyAfter", int'(busy), 0);

      clearSeen();
      applyStimulus(0, 1, 20, "out.b");
      applyStimulus(1, 1, 20, "out.ba");
      applyStimulus(1, 0, 20, "out.a");
      applyStimulus(0, 0, 20, "out.clr");
      checkCount("out.exitCount", seenExit, 1);
      checkCount("out.entryCount", seenEntry, 0);

      clearSeen();
      applyStimulus(1, 0, 20, "back.a");
      applyStimulus(0, 0, 20, "back.clr");
      checkCount("back.events", seenEntry + seenExit, 0);
      checkCount("back.busyAfter", int'(busy), 0);

      clearSeen();
      applyStimulus(1, 0, TB_TIMEOUT + 20, "stuck.a");
      checkCount("stuck.fault", int'(fault), 1);
      applyStimulus(0, 0, 20, "stuck.clr");
      checkCount("stuck.faultAfter", int'(fault), 0);
      checkCount("stuck.events", seenEntry + seenExit, 0);

      clearSeen();
      applyStimulus(1, 0, 2, "glitch.a");
      applyStimulus(0, 0, 20, "glitch.clr");
      checkCount("glitch.events", seenEntry + seenExit, 0);
`ifdef GATE_DEBOUNCE_EN
      checkCount("glitch.busyCycles", seenBusy, 0);
`endif

      clearSeen();
      applyStimulus(1, 0, 20, "rst.a");
      applyStimulus(1, 1, 20, "rst.ab");
      applyStimulus(0, 1, 20, "rst.b");
      rstN = 1'b0;
      stepCycle("rst.pulse");
      checkCount("rst.outputs", int'({entry, exitEv, busy, fault}), 0);
      rstN = 1'b1;
      applyStimulus(0, 1, 10, "rst.hold");
      applyStimulus(0, 0, 20, "rst.clr");
      checkCount("rst.entryCount", seenEntry, 0);

      // Random traffic: ordered crossings with jittery holds mixed with arbitrary beam noise
      for (int seg = 0; seg < 120; seg++) begin
         if ($urandom_range(0, 39) == 0) begin
            rstN = 1'b0;
            stepCycle("rand.rst");
            rstN = 1'b1;
         end
         if ($urandom_range(0, 1) == 1) begin
            bit inbound;
            inbound = 1'($urandom_range(0, 1));
            for (int s = 1; s <= 4; s++) begin
               bit [1:0] lt;
               int hold;
               lt = stepPattern(s);
               hold = ($urandom_range(0, 15) == 0) ? TB_TIMEOUT + 5 : int'($urandom_range(1, 14));
               if (inbound) applyStimulus(lt[1], lt[0], hold, "rand.cross");
               else applyStimulus(lt[0], lt[1], hold, "rand.cross");
            end
         end else begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 12)), "rand.noise");
         end
      end
      applyStimulus(0, 0, 20, "final.clr");
      checkCount("final.busy", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
